wb_write_arbiter: RTL and testbench
===================================

// Module: wb_write_arbiter
// PURPOSE
//  Writeback stage directly upstream of the 32x64 register file's single write port.
//  Merges ALU results (fixed-latency, never stalled) with out-of-order load/NIC returns
//  (valid/ready, buffered in a small FIFO) into one registered write stream.
//  Keeps a pending-load scoreboard that decode uses for RAW/WAW hazard interlock.
// PARAMETERS
//  DEPTH       32              number of architectural registers
//  DATA_WIDTH  64              register width
//  ADDR_WIDTH  $clog2(DEPTH)   register address width
//  FIFO_DEPTH  4               load-return buffer entries; power of 2, >=2
// PORTS
//  clk           in   1            clock
//  reset         in   1            synchronous, active-high
//  alu_vld       in   1            ALU writeback request this cycle
//  alu_addr      in   ADDR_WIDTH   ALU destination register
//  alu_data      in   DATA_WIDTH   ALU result
//  ld_vld        in   1            load return valid
//  ld_rdy        out  1            load return ready (FIFO not full)
//  ld_addr       in   ADDR_WIDTH   load destination register
//  ld_data       in   DATA_WIDTH   load data
//  ld_issue_vld  in   1            decode issued a load (sets scoreboard bit)
//  ld_issue_addr in   ADDR_WIDTH   destination register of the issued load
//  wr_en         out  1            to regfile wrEn
//  wr_addr       out  ADDR_WIDTH   to regfile wrAddr
//  wr_data       out  DATA_WIDTH   to regfile dataIn
//  pend          out  DEPTH        bit i = load to r[i] outstanding
//  fifo_cnt      out  $clog2(FIFO_DEPTH+1)  occupied FIFO entries
// BEHAVIOUR
//  - Reset: wr_en/wr_addr/wr_data=0, pend=0, FIFO flushed (fifo_cnt=0), ld_rdy=1 next cycle.
//    Reset mid-operation discards all queued returns; outputs reset at the same edge.
//  - Load accept: ld_vld && ld_rdy. ld_rdy = (fifo_cnt != FIFO_DEPTH), from state only.
//    No pass-through when full: ld_rdy stays low even if a dequeue occurs that cycle.
//    Accepted load with ld_addr==0 is dropped (not enqueued, fifo_cnt unchanged).
//  - Port select per cycle (ALU strict priority):
//    1) alu_vld && alu_addr!=0 -> next edge: wr_en=1, wr_addr/wr_data=ALU. Latency 1.
//    2) else FIFO non-empty -> pop head; next edge: wr_en=1 with head addr/data.
//    3) else next edge: wr_en=0; wr_addr/wr_data hold last value (don't-care).
//    alu_vld with alu_addr==0 does not occupy the port.
//  - Load latency: accepted at edge t, earliest wr_en at edge t+2 (enqueue, then pop/register).
//  - FIFO order strictly FIFO; enqueue and dequeue in one cycle allowed (cnt unchanged).
//  - Continuous ALU traffic may starve loads; FIFO fills and ld_rdy backpressures. Intended.
//  - Scoreboard: ld_issue_vld && ld_issue_addr!=0 sets pend[addr] at next edge.
//    Pop of entry with addr a clears pend[a] at the same edge wr_en rises, so regfile
//    bypass covers the consumer. Same-cycle set and clear on one address: set wins.
//  - Protocol violations (assertion only, no RTL recovery): ld_issue to address already
//    pending; alu_vld to address with pend set; ld return to address with pend clear.
// STRUCTURE
//  - Shared package: DEPTH/DATA_WIDTH/ADDR_WIDTH constants, typedef wb_req_t {addr,data}.
//  - Sub-module wb_load_fifo: sync FIFO of wb_req_t, FIFO_DEPTH entries, push/pop/cnt,
//    wrap-around read/write pointers (extra MSB for full/empty).
//  - Top: select logic, output register, scoreboard register, assertions.
// TESTING
//  1 Reset: hold reset 2 cycles with ld_vld=1 -> wr_en=0, pend=0, fifo_cnt=0, ld_rdy=1.
//  2 ALU only: alu_vld, r5=0xDEAD_BEEF at t -> wr_en=1, wr_addr=5, wr_data=0xDEADBEEF at t+1;
//    alu_addr=0 -> wr_en=0.
//  3 Load path: issue r7 (pend[7]=1), return r7=0x1234 at t -> wr_en at t+2, pend[7]=0 same edge.
//  4 Collision: ALU r3 every cycle for 6 cycles while loads r8..r12 return -> ld_rdy low after
//    4 accepts; loads drain in order r8..r12 once ALU idles; no data lost.
//  5 Simultaneous: pop of r9 and ld_issue r9 same cycle -> pend[9]=1 afterwards.
//  6 Reset mid-drain: reset with fifo_cnt=3 -> FIFO empty, pend=0, no further wr_en.

Source files
------------

// File: rtl/wb_write_arbiter_pkg.sv
// Shared constants and the writeback request type used by the arbiter and its load FIFO.
package wb_write_arbiter_pkg;

    localparam int DEPTH      = 32;
    localparam int DATA_WIDTH = 64;
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_WIDTH  = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_load_fifo.sv
// Synchronous FIFO buffering load/NIC returns until the regfile write port is free.
module wb_load_fifo
    import wb_write_arbiter_pkg::*;
#(
    parameter int ENTRIES = FIFO_DEPTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  wb_req_t                        push_req,
    input  logic                           pop,
    output wb_req_t                        head,
    output logic                           empty,
    output logic                           full,
    output logic [$clog2(ENTRIES+1)-1:0]   cnt
);

    localparam int PW = $clog2(ENTRIES);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    wb_req_t     mem [ENTRIES];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign cnt   = $bits(cnt)'(wr_ptr - rd_ptr);
    assign head  = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (PW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (PW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full && !reset) begin
            mem[wr_ptr[PW-1:0]] <= push_req;
        end
    end

endmodule

// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: ALU results take strict priority over buffered load returns for the
// single regfile write port; a pending-load scoreboard feeds decode's hazard interlock.
module wb_write_arbiter
    import wb_write_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_vld,
    input  logic [ADDR_WIDTH-1:0] alu_addr,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  ld_vld,
    output logic                  ld_rdy,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    input  logic                  ld_issue_vld,
    input  logic [ADDR_WIDTH-1:0] ld_issue_addr,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [DEPTH-1:0]      pend,
    output logic [CNT_WIDTH-1:0]  fifo_cnt
);

    wb_req_t          head;
    wb_req_t          push_req;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic             alu_sel;
    logic [DEPTH-1:0] pend_nxt;

    // Ready comes from FIFO state alone; a same-cycle pop never frees a slot early.
    assign ld_rdy   = !fifo_full;
    assign push     = ld_vld && ld_rdy && (ld_addr != '0);
    assign push_req = '{addr: ld_addr, data: ld_data};
    assign alu_sel  = alu_vld && (alu_addr != '0);
    assign pop      = !alu_sel && !fifo_empty;

    wb_load_fifo #(
        .ENTRIES (FIFO_DEPTH)
    ) u_load_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_req (push_req),
        .pop      (pop),
        .head     (head),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .cnt      (fifo_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (alu_sel) begin
            wr_en   <= 1'b1;
            wr_addr <= alu_addr;
            wr_data <= alu_data;
        end else if (pop) begin
            wr_en   <= 1'b1;
            wr_addr <= head.addr;
            wr_data <= head.data;
        end else begin
            wr_en   <= 1'b0;
        end
    end

    // Clear lands on the same edge wr_en rises; a new issue to that register wins.
    always_comb begin
        pend_nxt = pend;
        if (pop) begin
            pend_nxt[head.addr] = 1'b0;
        end
        if (ld_issue_vld && (ld_issue_addr != '0)) begin
            pend_nxt[ld_issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend <= '0;
        end else begin
            pend <= pend_nxt;
        end
    end

    a_issue_not_pending : assert property (@(posedge clk) disable iff (reset)
        (ld_issue_vld && (ld_issue_addr != '0)) |->
            (!pend[ld_issue_addr] || (pop && (head.addr == ld_issue_addr))))
        else $error("load issued to r%0d which already has a load outstanding", ld_issue_addr);

    a_alu_not_pending : assert property (@(posedge clk) disable iff (reset)
        alu_sel |-> !pend[alu_addr])
        else $error("ALU writeback to r%0d while a load to it is outstanding", alu_addr);

    a_return_pending : assert property (@(posedge clk) disable iff (reset)
        push |-> pend[ld_addr])
        else $error("load return to r%0d with no outstanding load", ld_addr);

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter with a queue-based reference model checked every cycle.
module tb_wb_write_arbiter;
    import wb_write_arbiter_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  alu_vld = 1'b0;
    logic [ADDR_WIDTH-1:0] alu_addr = '0;
    logic [DATA_WIDTH-1:0] alu_data = '0;
    logic                  ld_vld = 1'b0;
    logic                  ld_rdy;
    logic [ADDR_WIDTH-1:0] ld_addr = '0;
    logic [DATA_WIDTH-1:0] ld_data = '0;
    logic                  ld_issue_vld = 1'b0;
    logic [ADDR_WIDTH-1:0] ld_issue_addr = '0;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DEPTH-1:0]      pend;
    logic [CNT_WIDTH-1:0]  fifo_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_write_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .alu_vld       (alu_vld),
        .alu_addr      (alu_addr),
        .alu_data      (alu_data),
        .ld_vld        (ld_vld),
        .ld_rdy        (ld_rdy),
        .ld_addr       (ld_addr),
        .ld_data       (ld_data),
        .ld_issue_vld  (ld_issue_vld),
        .ld_issue_addr (ld_issue_addr),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .pend          (pend),
        .fifo_cnt      (fifo_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a plain queue of returns and a pending bit array.
    wb_req_t               m_q[$];
    logic [DEPTH-1:0]      m_pend;
    logic                  m_wr_en;
    logic [ADDR_WIDTH-1:0] m_wr_addr;
    logic [DATA_WIDTH-1:0] m_wr_data;
    bit                    m_ok = 1'b0;

    always @(posedge clk) begin : model
        bit      rdy;
        wb_req_t h;
        if (reset) begin
            m_q.delete();
            m_pend    = '0;
            m_wr_en   = 1'b0;
            m_wr_addr = '0;
            m_wr_data = '0;
            m_ok      = 1'b1;
        end else begin
            rdy = (m_q.size() < FIFO_DEPTH);
            if (alu_vld && alu_addr != 0) begin
                m_wr_en   = 1'b1;
                m_wr_addr = alu_addr;
                m_wr_data = alu_data;
            end else if (m_q.size() > 0) begin
                h = m_q.pop_front();
                m_wr_en   = 1'b1;
                m_wr_addr = h.addr;
                m_wr_data = h.data;
                m_pend[h.addr] = 1'b0;
            end else begin
                m_wr_en = 1'b0;
            end
            if (ld_vld && rdy && ld_addr != 0) begin
                h.addr = ld_addr;
                h.data = ld_data;
                m_q.push_back(h);
            end
            if (ld_issue_vld && ld_issue_addr != 0) m_pend[ld_issue_addr] = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("cyc_wr_en", 64'(wr_en), 64'(m_wr_en));
            if (m_wr_en) begin
                chk("cyc_wr_addr", 64'(wr_addr), 64'(m_wr_addr));
                chk("cyc_wr_data", wr_data, m_wr_data);
            end
            chk("cyc_pend", 64'(pend), 64'(m_pend));
            chk("cyc_fifo_cnt", 64'(fifo_cnt), 64'(m_q.size()));
            chk("cyc_ld_rdy", 64'(ld_rdy), 64'(m_q.size() < FIFO_DEPTH));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench did not complete");
    end

    initial begin
        // Reset held two cycles with a load return offered
        reset   = 1'b1;
        ld_vld  = 1'b1;
        ld_addr = 5'd5;
        ld_data = 64'h55;
        step();
        step();
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", wr_data, 64'd0);
        chk("rst_pend", 64'(pend), 64'd0);
        chk("rst_fifo_cnt", 64'(fifo_cnt), 64'd0);
        chk("rst_ld_rdy", 64'(ld_rdy), 64'd1);
        reset  = 1'b0;
        ld_vld = 1'b0;

        // ALU path, latency 1; r0 does not occupy the port
        alu_vld  = 1'b1;
        alu_addr = 5'd5;
        alu_data = 64'hDEAD_BEEF;
        step();
        chk("alu_wr_en", 64'(wr_en), 64'd1);
        chk("alu_wr_addr", 64'(wr_addr), 64'd5);
        chk("alu_wr_data", wr_data, 64'hDEAD_BEEF);
        alu_addr = 5'd0;
        step();
        chk("alu_r0_wr_en", 64'(wr_en), 64'd0);
        alu_vld = 1'b0;

        // Load path: issue r7, return two edges later clears pend[7]
        ld_issue_vld  = 1'b1;
        ld_issue_addr = 5'd7;
        step();
        chk("ld_issue_pend7", 64'(pend[7]), 64'd1);
        ld_issue_vld = 1'b0;
        ld_vld  = 1'b1;
        ld_addr = 5'd7;
        ld_data = 64'h1234;
        step();
        chk("ld_enq_wr_en", 64'(wr_en), 64'd0);
        chk("ld_enq_cnt", 64'(fifo_cnt), 64'd1);
        ld_vld = 1'b0;
        step();
        chk("ld_wr_en", 64'(wr_en), 64'd1);
        chk("ld_wr_addr", 64'(wr_addr), 64'd7);
        chk("ld_wr_data", wr_data, 64'h1234);
        chk("ld_pend7_clr", 64'(pend[7]), 64'd0);

        // Collision: ALU r3 every cycle while loads r8..r12 return
        for (int a = 8; a <= 12; a++) begin
            ld_issue_vld  = 1'b1;
            ld_issue_addr = 5'(a);
            step();
        end
        ld_issue_vld = 1'b0;
        chk("col_pend", 64'(pend[12:8]), 64'h1f);
        alu_vld  = 1'b1;
        alu_addr = 5'd3;
        for (int i = 0; i < 6; i++) begin
            alu_data = 64'hA0 + 64'(i);
            ld_vld   = 1'b1;
            ld_addr  = (i < 4) ? 5'(8 + i) : 5'd12;
            ld_data  = 64'h100 + 64'(ld_addr);
            step();
            chk("col_alu_addr", 64'(wr_addr), 64'd3);
            chk("col_alu_data", wr_data, 64'hA0 + 64'(i));
            if (i >= 3) begin
                chk("col_full_rdy", 64'(ld_rdy), 64'd0);
                chk("col_full_cnt", 64'(fifo_cnt), 64'd4);
            end
        end
        alu_vld = 1'b0;
        chk("col_nopass_rdy", 64'(ld_rdy), 64'd0);
        step();
        chk("col_drain_r8", 64'(wr_addr), 64'd8);
        chk("col_drain_cnt", 64'(fifo_cnt), 64'd3);
        step();
        chk("col_drain_r9", 64'(wr_addr), 64'd9);
        chk("col_r12_acc_cnt", 64'(fifo_cnt), 64'd3);
        ld_vld = 1'b0;
        for (int a = 10; a <= 12; a++) begin
            step();
            chk("col_drain_en", 64'(wr_en), 64'd1);
            chk("col_drain_addr", 64'(wr_addr), 64'(a));
            chk("col_drain_data", wr_data, 64'h100 + 64'(a));
        end
        step();
        chk("col_idle_en", 64'(wr_en), 64'd0);
        chk("col_idle_cnt", 64'(fifo_cnt), 64'd0);
        chk("col_pend_clr", 64'(pend[12:8]), 64'd0);

        // Pop of r9 and issue of r9 in the same cycle: set wins
        ld_issue_vld  = 1'b1;
        ld_issue_addr = 5'd9;
        step();
        ld_issue_vld = 1'b0;
        ld_vld  = 1'b1;
        ld_addr = 5'd9;
        ld_data = 64'h999;
        step();
        ld_vld        = 1'b0;
        ld_issue_vld  = 1'b1;
        ld_issue_addr = 5'd9;
        step();
        ld_issue_vld = 1'b0;
        chk("sim_wr_addr", 64'(wr_addr), 64'd9);
        chk("sim_wr_data", wr_data, 64'h999);
        chk("sim_pend9", 64'(pend[9]), 64'd1);

        // Reset mid-drain with three queued returns
        for (int a = 13; a <= 15; a++) begin
            ld_issue_vld  = 1'b1;
            ld_issue_addr = 5'(a);
            step();
        end
        ld_issue_vld = 1'b0;
        alu_vld  = 1'b1;
        alu_addr = 5'd3;
        for (int a = 13; a <= 15; a++) begin
            ld_vld  = 1'b1;
            ld_addr = 5'(a);
            ld_data = 64'h200 + 64'(a);
            step();
        end
        ld_vld = 1'b0;
        chk("mid_cnt3", 64'(fifo_cnt), 64'd3);
        alu_vld = 1'b0;
        reset   = 1'b1;
        step();
        chk("mid_rst_cnt", 64'(fifo_cnt), 64'd0);
        chk("mid_rst_pend", 64'(pend), 64'd0);
        chk("mid_rst_wr_en", 64'(wr_en), 64'd0);
        chk("mid_rst_rdy", 64'(ld_rdy), 64'd1);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mid_post_wr_en", 64'(wr_en), 64'd0);
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
